// File: rtl/muxnx1_tree_pipe.sv
// rtl/muxnx1_tree_pipe.sv - N:1 binary select tree with valid/ready handshake; MUXTREE_PIPE_EN registers every tree level
module muxnx1_tree_pipe #(
    parameter int N = 7,
    parameter int W = 8,
    localparam int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  i,
    input  logic [SW-1:0]   s,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    Y,
    output logic            sel_err
);

    localparam int P = 1 << SW;
    localparam logic [SW:0] N_LIM = (SW + 1)'(N);
`ifdef MUXTREE_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic           adv;
    logic           in_err;
    logic [P*W-1:0] pad;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign in_err   = {1'b0, s} >= N_LIM;

    // Out-of-range requests enter the tree as all zeros, so Y = 0 falls out naturally.
    for (genvar j = 0; j < P; j++) begin : g_pad
        if (j < N) begin : g_ch
            assign pad[j*W +: W] = in_err ? '0 : i[j*W +: W];
        end else begin : g_zero
            assign pad[j*W +: W] = '0;
        end
    end

    for (genvar k = 0; k < SW; k++) begin : g_lvl
        localparam int IE = P >> k;
        localparam int OE = IE / 2;

        logic [IE*W-1:0] a_d;
        logic [SW-k-1:0] a_s;
        logic            a_e;
        logic            a_v;
        logic [OE*W-1:0] m_d;
        logic [OE*W-1:0] q_d;
        logic            q_e;
        logic            q_v;

        if (k == 0) begin : g_src
            assign a_d = pad;
            assign a_s = s;
            assign a_e = in_err;
            assign a_v = in_valid;
        end else begin : g_src
            assign a_d = g_lvl[k-1].q_d;
            assign a_s = g_lvl[k-1].g_sel.q_s;
            assign a_e = g_lvl[k-1].q_e;
            assign a_v = g_lvl[k-1].q_v;
        end

        for (genvar j = 0; j < OE; j++) begin : g_mux
            assign m_d[j*W +: W] = a_s[0] ? a_d[(2*j+1)*W +: W] : a_d[2*j*W +: W];
        end

        // Without pipelining only the last level holds a register: the output stage.
        if (PIPE || k == SW - 1) begin : g_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_d <= '0;
                    q_e <= 1'b0;
                    q_v <= 1'b0;
                end else if (adv) begin
                    q_d <= m_d;
                    q_e <= a_e;
                    q_v <= a_v;
                end
            end
        end else begin : g_reg
            assign q_d = m_d;
            assign q_e = a_e;
            assign q_v = a_v;
        end

        if (k < SW - 1) begin : g_sel
            logic [SW-k-2:0] q_s;
            if (PIPE) begin : g_sq
                always_ff @(posedge clk) begin
                    if (adv) q_s <= a_s[SW-k-1:1];
                end
            end else begin : g_sq
                assign q_s = a_s[SW-k-1:1];
            end
        end
    end

    assign Y         = g_lvl[SW-1].q_d;
    assign sel_err   = g_lvl[SW-1].q_e;
    assign out_valid = g_lvl[SW-1].q_v;

endmodule

// File: tb/tb_muxnx1_tree_pipe.sv
// tb/tb_muxnx1_tree_pipe.sv - self-checking bench for muxnx1_tree_pipe against a queue-based reference model
module tb_muxnx1_tree_pipe;

    localparam int N  = 7;
    localparam int W  = 8;
    localparam int SW = $clog2(N);
    localparam int N5 = 5;
    localparam int S5 = $clog2(N5);
`ifdef MUXTREE_PIPE_EN
    localparam int LAT  = SW;
    localparam int LAT5 = S5;
`else
    localparam int LAT  = 1;
    localparam int LAT5 = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           in_valid, in_ready, out_valid, out_ready, sel_err;
    logic [N*W-1:0] i;
    logic [SW-1:0]  s;
    logic [W-1:0]   y;

    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_sel_err;
    logic [1:0] b_i;
    logic [0:0] b_s;
    logic [0:0] b_y;

    logic            c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_sel_err;
    logic [N5*W-1:0] c_i;
    logic [S5-1:0]   c_s;
    logic [W-1:0]    c_y;

    muxnx1_tree_pipe #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .i(i), .s(s),
        .out_valid(out_valid), .out_ready(out_ready), .Y(y), .sel_err(sel_err));

    muxnx1_tree_pipe #(.N(2), .W(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .i(b_i), .s(b_s),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .Y(b_y), .sel_err(b_sel_err));

    muxnx1_tree_pipe #(.N(N5), .W(W)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .i(c_i), .s(c_s),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .Y(c_y), .sel_err(c_sel_err));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W:0] exp_q[$];
    logic [W:0] obs_q[$];
    int         acc_cyc[$];
    int         out_cyc[$];

    function automatic logic [W:0] model(logic [N*W-1:0] iv, int sv);
        if (sv >= N) return {1'b1, {W{1'b0}}};
        return {1'b0, iv[sv*W +: W]};
    endfunction

    task automatic clear_q();
        exp_q.delete(); obs_q.delete(); acc_cyc.delete(); out_cyc.delete();
    endtask

    // One clock of the main instance: records accepts (model) and deliveries (observed).
    task automatic tick();
        @(negedge clk);
        if (in_valid && in_ready) begin
            exp_q.push_back(model(i, int'(s)));
            acc_cyc.push_back(cyc);
        end
        if (out_valid && out_ready) begin
            obs_q.push_back({sel_err, y});
            out_cyc.push_back(cyc);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(int n);
        in_valid = 1'b0;
        for (int w = 0; w < 30 && obs_q.size() < n; w++) tick();
    endtask

    task automatic set_ramp();
        for (int k = 0; k < N; k++) i[k*W +: W] = W'(17 * k);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 0; out_ready = 1; i = '0; s = '0;
        b_in_valid = 0; b_out_ready = 1; b_i = '0; b_s = '0;
        c_in_valid = 0; c_out_ready = 1; c_i = '0; c_s = '0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (y !== '0) begin errors++; $display("FAIL reset_y got=%h want=00", y); end
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got=%b want=0", sel_err); end
        checks++; if (b_out_valid !== 1'b0 || c_out_valid !== 1'b0) begin errors++; $display("FAIL reset_small_valid got=%b%b want=00", b_out_valid, c_out_valid); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_sweep();
        clear_q();
        set_ramp();
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1; s = SW'(k);
            tick();
        end
        drain(N);
        checks++; if (obs_q.size() !== N) begin errors++; $display("FAIL sweep_count got=%0d want=%0d", obs_q.size(), N); end
        for (int k = 0; k < N && k < obs_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k] || obs_q[k] !== {1'b0, W'(17 * k)})
                begin errors++; $display("FAIL sweep_data[%0d] got=%h want=%h", k, obs_q[k], exp_q[k]); end
            checks++;
            if (out_cyc[k] - acc_cyc[k] !== LAT || out_cyc[k] !== out_cyc[0] + k)
                begin errors++; $display("FAIL sweep_latency[%0d] got=%0d want=%0d", k, out_cyc[k] - acc_cyc[k], LAT); end
        end
    endtask

    task automatic test_err();
        clear_q();
        set_ramp();
        out_ready = 1'b1;
        in_valid = 1'b1; s = 3'd7; tick();
        s = 3'd6; tick();
        drain(2);
        checks++; if (obs_q.size() !== 2) begin errors++; $display("FAIL err_count got=%0d want=2", obs_q.size()); end
        else begin
            checks++; if (obs_q[0] !== {1'b1, 8'h00}) begin errors++; $display("FAIL err_s7 got=%h want=100", obs_q[0]); end
            checks++; if (obs_q[1] !== {1'b0, 8'h66}) begin errors++; $display("FAIL err_s6 got=%h want=066", obs_q[1]); end
        end
    endtask

    task automatic test_backpressure();
        int hold = 0;
        bit seen = 0;
        logic [W:0] held = '0;
        clear_q();
        out_ready = 1'b1;
        for (int c = 0; c < 60 && obs_q.size() < 5; c++) begin
            if (out_ready === 1'b0) begin
                checks++; if (out_valid !== 1'b1 || {sel_err, y} !== held)
                    begin errors++; $display("FAIL hold_stable got=%b/%h want=1/%h", out_valid, {sel_err, y}, held); end
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready got=%b want=0", in_ready); end
            end
            if (!seen && out_valid) begin seen = 1; held = {sel_err, y}; end
            if (seen && hold < 4) begin out_ready = 1'b0; hold++; end
            else out_ready = 1'b1;
            in_valid = (exp_q.size() < 5);
            i = {$urandom, $urandom};
            s = SW'($urandom_range(0, 7));
            tick();
        end
        out_ready = 1'b1;
        drain(5);
        checks++; if (obs_q.size() !== 5 || exp_q.size() !== 5)
            begin errors++; $display("FAIL bp_count got=%0d/%0d want=5", obs_q.size(), exp_q.size()); end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            checks++; if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL bp_data[%0d] got=%h want=%h", k, obs_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_bubbles();
        int n = 0;
        clear_q();
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_valid = (c % 2 == 0) || (c == 7);
            i = {$urandom, $urandom};
            s = SW'($urandom_range(0, 6));
            if (in_valid) n++;
            tick();
        end
        drain(n);
        checks++; if (obs_q.size() !== n) begin errors++; $display("FAIL bubble_count got=%0d want=%0d", obs_q.size(), n); end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k] || out_cyc[k] - acc_cyc[k] !== LAT)
                begin errors++; $display("FAIL bubble[%0d] got=%h@%0d want=%h@%0d", k, obs_q[k], out_cyc[k] - acc_cyc[k], exp_q[k], LAT); end
        end
    endtask

    task automatic test_reset_midstream();
        clear_q();
        set_ramp();
        out_ready = 1'b1;
        in_valid = 1'b1; s = 3'd6; tick();
        s = 3'd5; tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || y !== '0 || sel_err !== 1'b0)
            begin errors++; $display("FAIL midreset_async got=%b/%h/%b want=0/00/0", out_valid, y, sel_err); end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_q();
        for (int c = 0; c < 8; c++) tick();
        checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL midreset_stale got=%0d want=0", obs_q.size()); end
    endtask

    task automatic test_n2();
        int n;
        logic [1:0] want;
        for (int k = 0; k < 2; k++) begin
            b_i = 2'b10; b_s = 1'(k); b_in_valid = 1'b1;
            want = b_i;
            @(posedge clk); #1;
            b_in_valid = 1'b0;
            n = 1;
            while (!b_out_valid && n < 10) begin @(posedge clk); #1; n++; end
            checks++; if (b_out_valid !== 1'b1 || n !== 1 || b_y !== want[k] || b_sel_err !== 1'b0)
                begin errors++; $display("FAIL n2_s%0d got=%b/%0d/%b want=1/1/%b", k, b_out_valid, n, b_y, want[k]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_n5();
        int n;
        logic [W-1:0] want;
        for (int k = 0; k < 4; k++) begin
            for (int q = 0; q < N5; q++) c_i[q*W +: W] = W'($urandom);
            c_s = S5'((k == 0) ? 4 : k + 4);
            want = (k == 0) ? c_i[4*W +: W] : '0;
            c_in_valid = 1'b1;
            @(posedge clk); #1;
            c_in_valid = 1'b0;
            n = 1;
            while (!c_out_valid && n < 10) begin @(posedge clk); #1; n++; end
            checks++; if (c_out_valid !== 1'b1 || n !== LAT5 || c_y !== want || c_sel_err !== (k != 0))
                begin errors++; $display("FAIL n5_s%0d got=%b/%0d/%h/%b want=1/%0d/%h/%b", c_s, c_out_valid, n, c_y, c_sel_err, LAT5, want, k != 0); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_err();
        test_backpressure();
        test_bubbles();
        test_reset_midstream();
        test_n2();
        test_n5();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
